// File: rtl/softex_lane_dispatch.sv
// SoftEx lane dispatcher/merger: round-robin beat dispatch over n_act lanes, in-order merge via an order FIFO.
// Optional performance counters are enabled with `define SOFTEX_LANE_DISPATCH_PERF_EN.
module softex_lane_dispatch #(
  parameter int DATA_WIDTH  = 128,
  parameter int NUM_LANES   = 4,
  parameter int ORDER_DEPTH = 8,
  parameter int LW          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic [$clog2(NUM_LANES+1)-1:0]  active_lanes_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [DATA_WIDTH-1:0]           in_data_i,
  input  logic                            in_last_i,
  output logic [NUM_LANES-1:0]            lane_valid_o,
  input  logic [NUM_LANES-1:0]            lane_ready_i,
  output logic [DATA_WIDTH-1:0]           lane_data_o,
  input  logic [NUM_LANES-1:0]            res_valid_i,
  output logic [NUM_LANES-1:0]            res_ready_o,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] res_data_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [DATA_WIDTH-1:0]           out_data_o,
  output logic                            out_last_o,
  output logic                            busy_o,
`ifdef SOFTEX_LANE_DISPATCH_PERF_EN
  output logic [31:0]                     perf_beats_o,
  output logic [31:0]                     perf_stall_o,
`endif
  output logic [$clog2(ORDER_DEPTH+1)-1:0] order_count_o
);

  localparam int AW  = $clog2(NUM_LANES + 1);
  localparam int OAW = $clog2(ORDER_DEPTH);
  localparam int OCW = $clog2(ORDER_DEPTH + 1);

  typedef struct packed {
    logic [LW-1:0] lane;
    logic          last;
  } order_t;

  logic [AW-1:0]         r_n_act;
  logic [AW-1:0]         w_n_act;
  logic [LW-1:0]         r_wr_lane;
  logic [LW-1:0]         w_wr_lane;
  logic [LW-1:0]         w_wr_next;
  logic [OAW:0]          r_wptr;
  logic [OAW:0]          r_rptr;
  order_t                r_order_mem [ORDER_DEPTH];
  order_t                w_head;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_busy;
  logic                  w_lane_rdy;
  logic                  w_push;
  logic                  w_res_rdy;
  logic                  w_head_valid;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_pop;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DATA_WIDTH-1:0] r_out_data;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[OAW] != r_rptr[OAW]) && (r_wptr[OAW-1:0] == r_rptr[OAW-1:0]);
  assign w_busy  = !w_empty || r_out_valid;
  assign w_head  = r_order_mem[r_rptr[OAW-1:0]];

  // The lane count follows the request while idle and freezes once a tile is in flight.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_n_act = r_n_act;
    if (!w_busy) begin
      if (active_lanes_i == '0)
        w_n_act = AW'(1);
      else if (active_lanes_i > AW'(NUM_LANES))
        w_n_act = AW'(NUM_LANES);
      else
        w_n_act = active_lanes_i;
    end
  end

  always_comb begin
    w_wr_lane = (32'(r_wr_lane) >= 32'(w_n_act)) ? '0 : r_wr_lane;
    if (in_last_i || (32'(w_wr_lane) + 32'd1 >= 32'(w_n_act)))
      w_wr_next = '0;
    else
      w_wr_next = w_wr_lane + LW'(1);
  end

  always_comb begin
    w_lane_rdy   = 1'b0;
    w_head_valid = 1'b0;
    w_head_data  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_wr_lane == LW'(i))
        w_lane_rdy = lane_ready_i[i];
      if (w_head.lane == LW'(i)) begin
        w_head_valid = res_valid_i[i];
        w_head_data  = res_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_push    = in_valid_i && w_lane_rdy && !w_full && !rst_i;
  assign w_res_rdy = !w_empty && (!r_out_valid || out_ready_i) && !rst_i;
  assign w_pop     = w_res_rdy && w_head_valid;

  always_comb begin
    lane_valid_o = '0;
    res_ready_o  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_valid_o[i] = (w_wr_lane == LW'(i)) && in_valid_i && !w_full && !rst_i;
      res_ready_o[i]  = (w_head.lane == LW'(i)) && w_res_rdy;
    end
  end

  // Every output reads as zero while reset is held, including the registered ones.
  assign in_ready_o    = w_lane_rdy && !w_full && !rst_i;
  assign lane_data_o   = rst_i ? '0 : in_data_i;
  assign out_valid_o   = r_out_valid && !rst_i;
  assign out_data_o    = rst_i ? '0 : r_out_data;
  assign out_last_o    = r_out_last && !rst_i;
  assign busy_o        = w_busy && !rst_i;
  assign order_count_o = rst_i ? '0 : OCW'(r_wptr - r_rptr);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_n_act     <= AW'(1);
      r_wr_lane   <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_n_act <= w_n_act;
      if (w_push) begin
        r_wptr    <= r_wptr + 1'b1;
        r_wr_lane <= w_wr_next;
      end
      if (w_pop) begin
        r_rptr      <= r_rptr + 1'b1;
        r_out_valid <= 1'b1;
        r_out_data  <= w_head_data;
        r_out_last  <= w_head.last;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // NOTE: order storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_push)
      r_order_mem[r_wptr[OAW-1:0]] <= '{lane: w_wr_lane, last: in_last_i};
  end

`ifdef SOFTEX_LANE_DISPATCH_PERF_EN
  logic [31:0] r_perf_beats;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_perf_beats <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push && (r_perf_beats != '1))
        r_perf_beats <= r_perf_beats + 32'd1;
      if (in_valid_i && !in_ready_o && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_beats_o = rst_i ? '0 : r_perf_beats;
  assign perf_stall_o = rst_i ? '0 : r_perf_stall;
`else
  // Default build: no performance counters.
`endif

endmodule
